// File: rtl/sp_instr_dispatch.sv
// Scratchpad-side dispatcher: pops execute->scratchpad instruction FIFO entries and sequences
// matrix load/store row requests or a GEMM request. Optional perf counters via SP_DISPATCH_PERF_EN.
module sp_instr_dispatch #(
  parameter int ADDR_W    = 32,
  parameter int MAT_W     = 4,
  parameter int ROWS      = 4,
  parameter int ROW_BYTES = 8,
  parameter int ENTRY_W   = 2 + MAT_W + ADDR_W,
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               fifo_empty,
  input  logic [ENTRY_W-1:0] fifo_rdata,
  output logic               fifo_ren,
  output logic               mem_req,
  output logic               mem_wen,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [MAT_W-1:0]   mem_mat,
  output logic [ROW_W-1:0]   mem_row,
  input  logic               mem_gnt,
  input  logic               mem_ack,
  output logic               gemm_req,
  output logic [15:0]        gemm_sel,
  output logic               gemm_new_weight,
  input  logic               gemm_ready,
  input  logic               gemm_done,
  output logic               load_complete,
  output logic               store_complete,
  output logic               gemm_complete,
  output logic               busy
`ifdef SP_DISPATCH_PERF_EN
  ,
  output logic [31:0]        perf_ld_cnt,
  output logic [31:0]        perf_st_cnt,
  output logic [31:0]        perf_gemm_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LS_ISSUE = 3'd1;
  localparam logic [2:0] LS_WAIT  = 3'd2;
  localparam logic [2:0] G_ISSUE  = 3'd3;
  localparam logic [2:0] G_WAIT   = 3'd4;
  localparam int ACK_W = $clog2(ROWS + 1);

  typedef struct packed {
    logic [1:0]        op;
    logic [MAT_W-1:0]  mat;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  logic [2:0]       state_q, state_d;
  entry_t           ent_q, ent_d, head;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  logic             ld_cmp_q, ld_cmp_d, st_cmp_q, st_cmp_d, g_cmp_q, g_cmp_d;
  logic             run_q;
  logic             ack_in;

  assign head   = entry_t'(fifo_rdata);
  assign ack_in = mem_ack && (state_q == LS_ISSUE || state_q == LS_WAIT);

  always_comb begin
    state_d   = state_q;
    ent_d     = ent_q;
    row_d     = row_q;
    ack_cnt_d = ack_cnt_q;
    ld_cmp_d  = 1'b0;
    st_cmp_d  = 1'b0;
    g_cmp_d   = 1'b0;
    fifo_ren  = 1'b0;
    // acks may land while rows are still being granted, so count them from LS_ISSUE on
    if (ack_in && ack_cnt_q != ACK_W'(ROWS)) ack_cnt_d = ack_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (run_q && !fifo_empty) begin
          fifo_ren  = 1'b1;
          ent_d     = head;
          row_d     = '0;
          ack_cnt_d = '0;
          case (head.op)
            2'b01, 2'b10: state_d = LS_ISSUE;
            2'b11:        state_d = G_ISSUE;
            default:      state_d = IDLE;
          endcase
        end
      end
      LS_ISSUE: begin
        if (mem_gnt) begin
          row_d = row_q + 1'b1;
          if (row_q == ROW_W'(ROWS - 1)) begin
            row_d   = '0;
            state_d = LS_WAIT;
          end
        end
      end
      LS_WAIT: begin
        if (ack_cnt_d == ACK_W'(ROWS)) begin
          state_d   = IDLE;
          ld_cmp_d  = (ent_q.op == 2'b01);
          st_cmp_d  = (ent_q.op == 2'b10);
          row_d     = '0;
          ack_cnt_d = '0;
        end
      end
      G_ISSUE: if (gemm_ready) state_d = G_WAIT;
      G_WAIT: begin
        if (gemm_done) begin
          state_d = IDLE;
          g_cmp_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      ent_q     <= '0;
      row_q     <= '0;
      ack_cnt_q <= '0;
      ld_cmp_q  <= 1'b0;
      st_cmp_q  <= 1'b0;
      g_cmp_q   <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ent_q     <= ent_d;
      row_q     <= row_d;
      ack_cnt_q <= ack_cnt_d;
      ld_cmp_q  <= ld_cmp_d;
      st_cmp_q  <= st_cmp_d;
      g_cmp_q   <= g_cmp_d;
      run_q     <= 1'b1;
    end
  end

  // request fields are zeroed outside their issue states so reset/idle drives all-zero
  always_comb begin
    mem_req         = 1'b0;
    mem_wen         = 1'b0;
    mem_addr        = '0;
    mem_mat         = '0;
    mem_row         = '0;
    gemm_req        = 1'b0;
    gemm_sel        = '0;
    gemm_new_weight = 1'b0;
    if (state_q == LS_ISSUE) begin
      mem_req  = 1'b1;
      mem_wen  = (ent_q.op == 2'b10);
      mem_addr = ent_q.addr + ADDR_W'(row_q) * ADDR_W'(ROW_BYTES);
      mem_mat  = ent_q.mat;
      mem_row  = row_q;
    end
    if (state_q == G_ISSUE) begin
      gemm_req        = 1'b1;
      gemm_sel        = ent_q.addr[15:0];
      gemm_new_weight = ent_q.mat[MAT_W-1];
    end
  end

  assign load_complete  = ld_cmp_q;
  assign store_complete = st_cmp_q;
  assign gemm_complete  = g_cmp_q;
  assign busy           = (state_q != IDLE);

`ifdef SP_DISPATCH_PERF_EN
  logic [31:0] perf_ld_cnt_q, perf_ld_cnt_d, perf_st_cnt_q, perf_st_cnt_d;
  logic [31:0] perf_gemm_cnt_q, perf_gemm_cnt_d, perf_stall_cnt_q, perf_stall_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    perf_ld_cnt_d    = sat_inc(perf_ld_cnt_q, ld_cmp_q);
    perf_st_cnt_d    = sat_inc(perf_st_cnt_q, st_cmp_q);
    perf_gemm_cnt_d  = sat_inc(perf_gemm_cnt_q, g_cmp_q);
    perf_stall_cnt_d = sat_inc(perf_stall_cnt_q,
                               (mem_req && !mem_gnt) || (gemm_req && !gemm_ready));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_ld_cnt_q    <= '0;
      perf_st_cnt_q    <= '0;
      perf_gemm_cnt_q  <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_ld_cnt_q    <= perf_ld_cnt_d;
      perf_st_cnt_q    <= perf_st_cnt_d;
      perf_gemm_cnt_q  <= perf_gemm_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_ld_cnt    = perf_ld_cnt_q;
  assign perf_st_cnt    = perf_st_cnt_q;
  assign perf_gemm_cnt  = perf_gemm_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_sp_instr_dispatch.sv
// Bench for sp_instr_dispatch: FIFO/SRAM/array responders, a request-level model checked
// every cycle at negedge, and directed scenarios with literal expectations.
module tb_sp_instr_dispatch;
  localparam int ADDR_W = 32, MAT_W = 4, ROWS = 4, ROW_BYTES = 8;
  localparam int ENTRY_W = 2 + MAT_W + ADDR_W;

  logic CLK = 1'b0, nRST = 1'b0;
  logic fifo_empty, fifo_ren, mem_req, mem_wen, mem_gnt, mem_ack;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [MAT_W-1:0] mem_mat;
  logic [1:0] mem_row;
  logic gemm_req, gemm_new_weight, gemm_ready, gemm_done;
  logic [15:0] gemm_sel;
  logic load_complete, store_complete, gemm_complete, busy;
`ifdef SP_DISPATCH_PERF_EN
  logic [31:0] perf_ld_cnt, perf_st_cnt, perf_gemm_cnt, perf_stall_cnt;
`endif

  sp_instr_dispatch dut (
    .CLK(CLK), .nRST(nRST), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_ren(fifo_ren),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_mat(mem_mat), .mem_row(mem_row),
    .mem_gnt(mem_gnt), .mem_ack(mem_ack), .gemm_req(gemm_req), .gemm_sel(gemm_sel),
    .gemm_new_weight(gemm_new_weight), .gemm_ready(gemm_ready), .gemm_done(gemm_done),
    .load_complete(load_complete), .store_complete(store_complete), .gemm_complete(gemm_complete),
    .busy(busy)
`ifdef SP_DISPATCH_PERF_EN
    , .perf_ld_cnt(perf_ld_cnt), .perf_st_cnt(perf_st_cnt), .perf_gemm_cnt(perf_gemm_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mat;
    logic [1:0]  row;
    logic        wen;
  } mreq_t;
  typedef struct {
    logic [15:0] sel;
    logic        nw;
  } greq_t;

  int errs = 0, checks = 0;
  logic [ENTRY_W-1:0] fifo_q[$], push_q[$];
  mreq_t exp_mem_q[$];
  greq_t exp_g_q[$];
  logic [31:0] addr_log[$];
  logic        wen_log[$];
  logic [3:0]  mat_log[$];
  greq_t       g_log[$];

  // responder controls set by the directed sequence
  int blk_row = -1, blk_len = 0, blk_cnt = 0, rdy_dly = 0;
  bit ack_hold = 0;
  int ack_pend = 0, g_cnt = 0, g_done_cnt = 0;
  // handshakes seen at negedge, applied by the driver after the following posedge
  bit d_pop = 0, d_hs_mem = 0, d_hs_g = 0;

  // model state
  int  m_kind = 0, m_acks = 0;
  bit  m_gwait = 0, exp_ld = 0, exp_st = 0, exp_g = 0, exp_mreq = 0, exp_greq = 0;
  bit  prv_mreq = 0, prv_mgnt = 0, prv_greq = 0, prv_grdy = 0;
  logic [38:0] prv_mtuple;
  logic [16:0] prv_gtuple;
  int  n_ld = 0, n_st = 0, n_g = 0, n_pop = 0, n_mreq_cyc = 0, n_greq_cyc = 0;
  mreq_t me;
  greq_t ge;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] mat, input logic [31:0] addr);
    mreq_t r;
    greq_t g;
    push_q.push_back({op, mat, addr});
    if (op == 2'b01 || op == 2'b10) begin
      for (int i = 0; i < ROWS; i++) begin
        r.addr = addr + 32'(i * ROW_BYTES);
        r.mat  = mat;
        r.row  = 2'(i);
        r.wen  = (op == 2'b10);
        exp_mem_q.push_back(r);
      end
    end else if (op == 2'b11) begin
      g.sel = addr[15:0];
      g.nw  = mat[3];
      exp_g_q.push_back(g);
    end
  endtask

  // compare process: DUT outputs against the model every cycle
  always @(negedge CLK) begin
    if (!nRST) begin
      m_kind = 0; m_acks = 0; m_gwait = 0;
      exp_ld = 0; exp_st = 0; exp_g = 0; exp_mreq = 0; exp_greq = 0;
      prv_mreq = 0; prv_greq = 0;
      d_pop = 0; d_hs_mem = 0; d_hs_g = 0;
    end else begin
      chk("load_complete", load_complete, exp_ld);
      chk("store_complete", store_complete, exp_st);
      chk("gemm_complete", gemm_complete, exp_g);
      if (exp_mreq) chk("pop_to_mem_req", mem_req, 1);
      if (exp_greq) chk("pop_to_gemm_req", gemm_req, 1);
      n_ld += int'(load_complete); n_st += int'(store_complete); n_g += int'(gemm_complete);
      exp_ld = 0; exp_st = 0; exp_g = 0; exp_mreq = 0; exp_greq = 0;
      chk("ren_while_empty", fifo_ren & fifo_empty, 0);
      d_pop = fifo_ren && !fifo_empty;
      if (d_pop) begin
        n_pop++;
        m_kind = int'(fifo_rdata[ENTRY_W-1 -: 2]);
        m_acks = 0;
        exp_mreq = (m_kind == 1 || m_kind == 2);
        exp_greq = (m_kind == 3);
      end
      if (mem_req) begin
        n_mreq_cyc++;
        if (prv_mreq && !prv_mgnt)
          chk("mem_stable", {mem_addr, mem_row, mem_mat, mem_wen}, prv_mtuple);
        if (mem_gnt) begin
          chk("mem_req_expected", exp_mem_q.size() != 0, 1);
          if (exp_mem_q.size() != 0) begin
            me = exp_mem_q.pop_front();
            chk("mem_addr", mem_addr, me.addr);
            chk("mem_row", mem_row, me.row);
            chk("mem_mat", mem_mat, me.mat);
            chk("mem_wen", mem_wen, me.wen);
          end
          addr_log.push_back(mem_addr); wen_log.push_back(mem_wen); mat_log.push_back(mem_mat);
        end
      end
      d_hs_mem = mem_req && mem_gnt;
      prv_mreq = mem_req; prv_mgnt = mem_gnt;
      prv_mtuple = {mem_addr, mem_row, mem_mat, mem_wen};
      if (mem_ack && (m_kind == 1 || m_kind == 2)) begin
        m_acks++;
        if (m_acks == ROWS) begin
          exp_ld = (m_kind == 1); exp_st = (m_kind == 2); m_kind = 0;
        end
      end
      if (gemm_req) begin
        n_greq_cyc++;
        if (prv_greq && !prv_grdy) chk("gemm_stable", {gemm_sel, gemm_new_weight}, prv_gtuple);
        if (gemm_ready) begin
          chk("gemm_req_expected", exp_g_q.size() != 0, 1);
          if (exp_g_q.size() != 0) begin
            ge = exp_g_q.pop_front();
            chk("gemm_sel", gemm_sel, ge.sel);
            chk("gemm_new_weight", gemm_new_weight, ge.nw);
          end
          ge.sel = gemm_sel; ge.nw = gemm_new_weight;
          g_log.push_back(ge);
          m_gwait = 1;
        end
      end
      d_hs_g = gemm_req && gemm_ready;
      prv_greq = gemm_req; prv_grdy = gemm_ready;
      prv_gtuple = {gemm_sel, gemm_new_weight};
      if (gemm_done && m_gwait && !d_hs_g) begin
        exp_g = 1; m_gwait = 0; m_kind = 0;
      end
    end
  end

  // driver: FIFO, SRAM bank and systolic-array responders, updated just after each posedge
  always @(posedge CLK) begin
    #1;
    if (!nRST) begin
      ack_pend = 0; mem_ack = 0; gemm_done = 0; g_done_cnt = 0; g_cnt = 0; gemm_ready = 0;
    end else begin
      if (d_pop) void'(fifo_q.pop_front());
      d_pop = 0;
      if (d_hs_mem) ack_pend++;
      if (!ack_hold && ack_pend > 0) begin mem_ack = 1; ack_pend--; end
      else mem_ack = 0;
      if (mem_req && int'(mem_row) == blk_row && blk_cnt < blk_len) begin
        mem_gnt = 0; blk_cnt++;
      end else mem_gnt = 1;
      if (gemm_req) begin gemm_ready = (g_cnt >= rdy_dly); g_cnt++; end
      else begin gemm_ready = 0; g_cnt = 0; end
      gemm_done = 0;
      if (g_done_cnt > 0) begin g_done_cnt--; if (g_done_cnt == 0) gemm_done = 1; end
      if (d_hs_g) g_done_cnt = 2;
    end
    while (push_q.size() != 0) fifo_q.push_back(push_q.pop_front());
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? '0 : fifo_q[0];
  end

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge CLK); n++;
    end while (n < 200 && (push_q.size() != 0 || fifo_q.size() != 0 || busy ||
                            exp_mem_q.size() != 0 || exp_g_q.size() != 0));
    if (n >= 200) chk({name, "_timeout"}, 1, 0);
    repeat (3) @(negedge CLK);
  endtask

  int b_ld, b_st, b_g, b_pop, b_mc, b_gc, n;

  task automatic snap();
    b_ld = n_ld; b_st = n_st; b_g = n_g; b_pop = n_pop; b_mc = n_mreq_cyc; b_gc = n_greq_cyc;
    addr_log.delete(); wen_log.delete(); mat_log.delete(); g_log.delete();
  endtask

  initial begin
    fifo_empty = 1; fifo_rdata = '0; mem_gnt = 0; mem_ack = 0; gemm_ready = 0; gemm_done = 0;
    repeat (2) @(posedge CLK);
    #2;
    chk("reset_outputs", 64'({fifo_ren, mem_req, mem_wen, mem_addr, mem_mat, mem_row, gemm_req,
        gemm_sel, gemm_new_weight, load_complete, store_complete, gemm_complete, busy}), 0);
    #1 nRST = 1;

    // load, immediate grant/ack
    snap(); push(2'b01, 4'd3, 32'h1000); wait_done("load");
    chk("load_n_addr", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("load_a0", addr_log[0], 32'h1000); chk("load_a1", addr_log[1], 32'h1008);
      chk("load_a2", addr_log[2], 32'h1010); chk("load_a3", addr_log[3], 32'h1018);
      chk("load_wen", wen_log[3], 0); chk("load_mat", mat_log[0], 3);
    end
    chk("load_strobes", n_ld - b_ld, 1);

    // store with address wrap
    snap(); push(2'b10, 4'd5, 32'hFFFF_FFF8); wait_done("store");
    chk("store_n_addr", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      chk("store_a0", addr_log[0], 32'hFFFF_FFF8); chk("store_a1", addr_log[1], 32'h0);
      chk("store_a2", addr_log[2], 32'h8); chk("store_a3", addr_log[3], 32'h10);
      chk("store_wen", wen_log[0], 1);
    end
    chk("store_strobes", n_st - b_st, 1);
    chk("store_no_load", n_ld - b_ld, 0);

    // GEMM with gemm_ready withheld 3 cycles
    snap(); rdy_dly = 3; push(2'b11, 4'b1000, 32'h0000_00A5); wait_done("gemm"); rdy_dly = 0;
    chk("gemm_req_cycles", n_greq_cyc - b_gc, 4);
    chk("gemm_n_accept", g_log.size(), 1);
    if (g_log.size() == 1) begin
      chk("gemm_sel_lit", g_log[0].sel, 16'h00A5); chk("gemm_nw_lit", g_log[0].nw, 1);
    end
    chk("gemm_strobes", n_g - b_g, 1);

    // illegal entry dropped, following load proceeds
    snap(); push(2'b00, 4'd2, 32'h1234); push(2'b01, 4'd1, 32'h2000); wait_done("illegal");
    chk("illegal_pops", n_pop - b_pop, 2);
    chk("illegal_ld", n_ld - b_ld, 1);
    chk("illegal_other", (n_st - b_st) + (n_g - b_g), 0);
    chk("illegal_first_addr", addr_log.size() > 0 ? addr_log[0] : 32'hDEAD, 32'h2000);

    // grant withheld 5 cycles on row 2
    snap(); blk_row = 2; blk_len = 5; blk_cnt = 0;
    push(2'b01, 4'd7, 32'h40); wait_done("gnt_stall"); blk_row = -1;
    chk("stall_req_cycles", n_mreq_cyc - b_mc, 9);
    chk("stall_ld", n_ld - b_ld, 1);

    // back-to-back store, GEMM, load
    snap(); push(2'b10, 4'd4, 32'h300); push(2'b11, 4'd1, 32'h0001_7777); push(2'b01, 4'd6, 32'h500);
    wait_done("b2b");
    chk("b2b_counts", {n_st - b_st, n_g - b_g, n_ld - b_ld}, {32'd1, 32'd1, 32'd1});
    chk("b2b_gemm_nw", g_log.size() == 1 ? g_log[0].nw : 1'b1, 0);

    // reset during LS_WAIT aborts with no strobe
    snap(); ack_hold = 1; push(2'b01, 4'd2, 32'h100);
    n = 0;
    while (addr_log.size() < 4 && n < 100) begin @(negedge CLK); n++; end
    if (n >= 100) chk("abort_grant_timeout", 1, 0);
    @(negedge CLK);
    chk("abort_in_wait", {busy, mem_req}, 2'b10);
    #2 nRST = 0;
    #1;
    chk("abort_outputs", 64'({fifo_ren, mem_req, mem_wen, mem_addr, mem_mat, mem_row, gemm_req,
        gemm_sel, gemm_new_weight, load_complete, store_complete, gemm_complete, busy}), 0);
    ack_hold = 0; exp_mem_q.delete();
    repeat (2) @(posedge CLK);
    #3 nRST = 1;
    repeat (10) @(negedge CLK);
    chk("abort_no_strobe", (n_ld - b_ld) + (n_st - b_st) + (n_g - b_g), 0);
    snap(); push(2'b01, 4'd1, 32'h200); wait_done("post_reset");
    chk("post_reset_ld", n_ld - b_ld, 1);
`ifdef SP_DISPATCH_PERF_EN
    chk("perf_ld", perf_ld_cnt, 32'(n_ld));
    chk("perf_gemm", perf_gemm_cnt, 32'(n_g));
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
